// File: rtl/mipi_csi_tx_packet_encoder_8b4lane.sv
// MIPI CSI-2 transmit packet encoder for four byte lanes: sync pattern, packet header with ECC,
// lane-aligned payload and CRC-16 footer, all driven from registered outputs.
module mipi_csi_tx_packet_encoder_8b4lane (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        pkt_start_i,
    input  logic [7:0]  pkt_type_i,
    input  logic [15:0] pkt_length_i,
    output logic        pkt_ready_o,
    input  logic [31:0] data_i,
    input  logic        data_valid_i,
    output logic        data_ready_o,
    output logic [31:0] data_o,
    output logic        output_valid_o,
    output logic        len_err_o,
    output logic        underrun_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        HEADER  = 3'd2,
        PAYLOAD = 3'd3,
        FOOTER  = 3'd4
    } state_t;

    // Each parity bit covers the Data ID / word-count bits selected by its mask.
    function automatic logic [7:0] csi_ecc(input logic [23:0] d);
        return {2'b00,
                ^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
                ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
    endfunction

    function automatic logic [15:0] crc16_word(input logic [15:0] crc_in, input logic [31:0] word);
        logic [15:0] c;
        c = crc_in;
        for (int b = 0; b < 4; b++) begin
            c = c ^ {8'h00, word[8*b +: 8]};
            for (int i = 0; i < 8; i++) begin
                if (c[0]) begin
                    c = {1'b0, c[15:1]} ^ 16'h8408;
                end else begin
                    c = {1'b0, c[15:1]};
                end
            end
        end
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  di_q, di_d;
    logic [15:0] wc_q, wc_d;
    logic [13:0] cnt_q, cnt_d;
    logic [15:0] crc_q, crc_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        data_ready_q, data_ready_d;
    logic        pkt_ready_q, pkt_ready_d;
    logic        len_err_q, len_err_d;
    logic        underrun_q, underrun_d;
    logic        req_long_s;
    logic        is_long_s;

    assign req_long_s = (pkt_type_i[5:0] > 6'h0F);
    assign is_long_s  = (di_q[5:0] > 6'h0F);

    // Next-state and next-output logic for the packet sequencer.
    always_comb begin
        state_d      = state_q;
        di_d         = di_q;
        wc_d         = wc_q;
        cnt_d        = cnt_q;
        crc_d        = crc_q;
        data_d       = 32'h0000_0000;
        valid_d      = 1'b0;
        data_ready_d = 1'b0;
        pkt_ready_d  = 1'b0;
        len_err_d    = 1'b0;
        underrun_d   = underrun_q;
        case (state_q)
            IDLE: begin
                pkt_ready_d = 1'b1;
                if (pkt_start_i && pkt_ready_q) begin
                    if (req_long_s && (pkt_length_i[1:0] != 2'b00)) begin
                        len_err_d = 1'b1;
                    end else begin
                        di_d        = pkt_type_i;
                        wc_d        = pkt_length_i;
                        cnt_d       = pkt_length_i[15:2];
                        crc_d       = 16'hFFFF;
                        data_d      = 32'hB8B8_B8B8;
                        valid_d     = 1'b1;
                        pkt_ready_d = 1'b0;
                        state_d     = SYNC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SYNC: begin
                data_d  = {csi_ecc({wc_q, di_q}), wc_q[15:8], wc_q[7:0], di_q};
                valid_d = 1'b1;
                if (is_long_s && (wc_q != 16'h0000)) begin
                    data_ready_d = 1'b1;
                    state_d      = PAYLOAD;
                end else begin
                    state_d = HEADER;
                end
            end
            HEADER: begin
                if (is_long_s) begin
                    state_d = FOOTER;
                end else begin
                    pkt_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            PAYLOAD: begin
                if (data_valid_i && data_ready_q) begin
                    data_d  = data_i;
                    valid_d = 1'b1;
                    crc_d   = crc16_word(crc_q, data_i);
                    // The counter saturates at zero so it can never wrap.
                    if (cnt_q <= 14'd1) begin
                        cnt_d   = 14'd0;
                        state_d = FOOTER;
                    end else begin
                        cnt_d        = cnt_q - 14'd1;
                        data_ready_d = 1'b1;
                    end
                end else begin
                    underrun_d   = 1'b1;
                    data_ready_d = 1'b1;
                end
            end
            FOOTER: begin
                data_d  = {16'h0000, crc_q[15:8], crc_q[7:0]};
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            di_q         <= 8'h00;
            wc_q         <= 16'h0000;
            cnt_q        <= 14'd0;
            crc_q        <= 16'hFFFF;
            data_q       <= 32'h0000_0000;
            valid_q      <= 1'b0;
            data_ready_q <= 1'b0;
            pkt_ready_q  <= 1'b1;
            len_err_q    <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            di_q         <= di_d;
            wc_q         <= wc_d;
            cnt_q        <= cnt_d;
            crc_q        <= crc_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            data_ready_q <= data_ready_d;
            pkt_ready_q  <= pkt_ready_d;
            len_err_q    <= len_err_d;
            underrun_q   <= underrun_d;
        end
    end

    assign pkt_ready_o    = pkt_ready_q;
    assign data_ready_o   = data_ready_q;
    assign data_o         = data_q;
    assign output_valid_o = valid_q;
    assign len_err_o      = len_err_q;
    assign underrun_o     = underrun_q;

endmodule

// File: tb/tb_mipi_csi_tx_packet_encoder_8b4lane.sv
// Scoreboard bench for the CSI-2 packet encoder: a byte-level reference model queues the
// expected output words and a negedge monitor compares every valid word in order.
module tb_mipi_csi_tx_packet_encoder_8b4lane;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset_i;
    logic        pkt_start_i;
    logic [7:0]  pkt_type_i;
    logic [15:0] pkt_length_i;
    logic        pkt_ready_o;
    logic [31:0] data_i;
    logic        data_valid_i;
    logic        data_ready_o;
    logic [31:0] data_o;
    logic        output_valid_o;
    logic        len_err_o;
    logic        underrun_o;

    int          n_checks = 0;
    int          n_pass = 0;
    int          valid_cnt = 0;
    logic        dready_seen = 1'b0;
    logic        exp_underrun = 1'b0;
    logic [31:0] last_word = 32'h0;
    logic [31:0] exp_q[$];
    logic [31:0] pay_q[$];

    always #5 clk = ~clk;

    mipi_csi_tx_packet_encoder_8b4lane dut (
        .clk_i(clk), .reset_i(reset_i), .pkt_start_i(pkt_start_i), .pkt_type_i(pkt_type_i),
        .pkt_length_i(pkt_length_i), .pkt_ready_o(pkt_ready_o), .data_i(data_i),
        .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_o(data_o),
        .output_valid_o(output_valid_o), .len_err_o(len_err_o), .underrun_o(underrun_o)
    );

    // ECC as the XOR of the syndrome column of every set bit of {WC, DI}.
    function automatic logic [7:0] ref_ecc(input logic [7:0] di, input logic [15:0] wc);
        logic [7:0] col [24] = '{8'h07, 8'h0B, 8'h0D, 8'h0E, 8'h13, 8'h15, 8'h16, 8'h19,
                                 8'h1A, 8'h1C, 8'h23, 8'h25, 8'h26, 8'h29, 8'h2A, 8'h2C,
                                 8'h31, 8'h32, 8'h34, 8'h38, 8'h1F, 8'h2F, 8'h37, 8'h3B};
        logic [23:0] d;
        logic [7:0]  e;
        d = {wc, di};
        e = 8'h00;
        for (int i = 0; i < 24; i++) if (d[i]) e = e ^ col[i];
        return e;
    endfunction

    function automatic logic [15:0] ref_crc(input bq_t b);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (b[i]) begin
            c = c ^ {8'h00, b[i]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

    function automatic bit is_long(input logic [7:0] di);
        return di[5:0] > 6'h0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    // Monitor: every valid output word must be the next queued expectation.
    always @(negedge clk) begin
        if (data_ready_o) dready_seen = 1'b1;
        if (output_valid_o) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got %h, want no output", data_o);
            end else begin
                check("scoreboard", data_o, exp_q.pop_front());
            end
            last_word = data_o;
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 100 && pkt_ready_o !== 1'b1; i++) @(negedge clk);
        if (pkt_ready_o !== 1'b1) begin
            n_checks++;
            $display("FAIL ready_timeout: got %b, want 1", pkt_ready_o);
        end
    endtask

    // Issues one request (at a negedge) and queues the model's expected words.
    task automatic start_req(input logic [7:0] di, input logic [15:0] wc);
        bq_t         bytes;
        logic [31:0] w;
        wait_ready();
        pkt_start_i  = 1'b1;
        pkt_type_i   = di;
        pkt_length_i = wc;
        if (!(is_long(di) && wc[1:0] != 2'b00)) begin
            exp_q.push_back(32'hB8B8B8B8);
            exp_q.push_back({ref_ecc(di, wc), wc[15:8], wc[7:0], di});
            if (is_long(di)) begin
                foreach (pay_q[i]) begin
                    w = pay_q[i];
                    exp_q.push_back(w);
                    for (int j = 0; j < 4; j++) bytes.push_back(w[8*j +: 8]);
                end
                exp_q.push_back({16'h0000, ref_crc(bytes)});
            end
        end
        @(posedge clk);
        @(negedge clk);
        pkt_start_i = 1'b0;
    endtask

    task automatic drive_payload(input int gap_at, input int gap_len, input int max_words);
        int   k = 0;
        int   g = gap_len;
        int   guard = 0;
        logic gap_prev = 1'b0;
        while (k < max_words && guard < 400) begin
            guard++;
            if (gap_prev) check("gap_invalid", 32'(output_valid_o), 32'd0);
            gap_prev = 1'b0;
            if (data_ready_o && k == gap_at && g > 0) begin
                data_valid_i = 1'b0;
                g--;
                exp_underrun = 1'b1;
                gap_prev = 1'b1;
            end else begin
                data_valid_i = 1'b1;
                data_i = pay_q[k];
                if (data_ready_o) k++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        data_valid_i = 1'b0;
        if (k < max_words) begin
            n_checks++;
            $display("FAIL payload_timeout: got %0d words, want %0d", k, max_words);
        end
    endtask

    task automatic run_pkt(input logic [7:0] di, input logic [15:0] wc, input int gap_at,
                           input int gap_len, input bit keep_payload);
        bit rejected;
        rejected = is_long(di) && (wc[1:0] != 2'b00);
        if (!keep_payload) begin
            pay_q.delete();
            if (is_long(di) && !rejected) repeat (int'(wc) / 4) pay_q.push_back($urandom);
        end
        start_req(di, wc);
        if (rejected) begin
            check("rand_len_err", 32'(len_err_o), 32'd1);
            check("rand_rej_ready", 32'(pkt_ready_o), 32'd1);
        end else if (is_long(di) && wc != 16'h0000) begin
            drive_payload(gap_at, gap_len, pay_q.size());
        end
        wait_ready();
        check("underrun_state", 32'(underrun_o), 32'(exp_underrun));
    endtask

    initial begin
        bq_t         s;
        logic [31:0] f1;
        int          vc0;
        reset_i = 1'b1; pkt_start_i = 1'b0; pkt_type_i = 8'h00; pkt_length_i = 16'h0000;
        data_i = 32'h0; data_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", data_o, 32'h0);
        check("rst_valid", 32'(output_valid_o), 32'd0);
        check("rst_dready", 32'(data_ready_o), 32'd0);
        check("rst_pready", 32'(pkt_ready_o), 32'd1);
        check("rst_lenerr", 32'(len_err_o), 32'd0);
        check("rst_underrun", 32'(underrun_o), 32'd0);
        reset_i = 1'b0;
        @(negedge clk);

        // Short frame start packet: exact cycle timing.
        pay_q.delete();
        start_req(8'h00, 16'h0001);
        check("short_t1_sync", data_o, 32'hB8B8B8B8);
        check("short_t1_busy", 32'(pkt_ready_o), 32'd0);
        @(negedge clk);
        check("short_t2_header", data_o, 32'h1A000100);
        check("short_t2_busy", 32'(pkt_ready_o), 32'd0);
        @(negedge clk);
        check("short_t3_ready", 32'(pkt_ready_o), 32'd1);
        check("short_t3_idle", 32'(output_valid_o), 32'd0);

        // CRC model sanity against the standard check string.
        s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        check("crc_model_123456789", 32'(ref_crc(s)), 32'h6F91);

        // Long packet "12345678".
        pay_q = '{32'h34333231, 32'h38373635};
        run_pkt(8'h2B, 16'd8, -1, 0, 1'b1);
        s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
        check("long8_footer", last_word, {16'h0000, ref_crc(s)});

        // Long packet with zero word count.
        dready_seen = 1'b0;
        pay_q.delete();
        start_req(8'h2C, 16'h0000);
        @(negedge clk);
        check("wc0_header", data_o, 32'h1600002C);
        wait_ready();
        check("wc0_footer", last_word, 32'h0000FFFF);
        check("wc0_no_dready", 32'(dready_seen), 32'd0);

        // Misaligned long word count is rejected.
        vc0 = valid_cnt;
        pay_q.delete();
        start_req(8'h2D, 16'd6);
        check("lenerr_pulse", 32'(len_err_o), 32'd1);
        check("lenerr_ready", 32'(pkt_ready_o), 32'd1);
        @(negedge clk);
        check("lenerr_one_cycle", 32'(len_err_o), 32'd0);
        check("lenerr_ready2", 32'(pkt_ready_o), 32'd1);
        check("lenerr_no_output", 32'(valid_cnt), 32'(vc0));

        // Same payload with and without a two-cycle starvation gap.
        pay_q.delete();
        repeat (4) pay_q.push_back($urandom);
        run_pkt(8'h2A, 16'd16, -1, 0, 1'b1);
        f1 = last_word;
        run_pkt(8'h2A, 16'd16, 2, 2, 1'b1);
        check("gap_crc_same", last_word, f1);
        check("underrun_set", 32'(underrun_o), 32'd1);
        run_pkt(8'h12, 16'h5A5A, -1, 0, 1'b0);

        // Reset in the middle of a payload.
        pay_q.delete();
        repeat (4) pay_q.push_back($urandom);
        start_req(8'h24, 16'd16);
        drive_payload(-1, 0, 2);
        data_valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        exp_q.delete();
        exp_underrun = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", 32'(output_valid_o), 32'd0);
        check("rst_mid_underrun", 32'(underrun_o), 32'd0);
        check("rst_mid_dready", 32'(data_ready_o), 32'd0);
        check("rst_mid_pready", 32'(pkt_ready_o), 32'd1);
        run_pkt(8'h2B, 16'd12, -1, 0, 1'b0);

        // Randomized packet mix.
        for (int n = 0; n < 25; n++) begin
            logic [7:0]  di;
            logic [15:0] wc;
            int          r;
            r = $urandom_range(0, 9);
            if (r < 3) begin
                di = {2'($urandom), 6'($urandom_range(0, 15))};
                wc = 16'($urandom);
            end else begin
                di = {2'($urandom), 6'($urandom_range(16, 63))};
                if (r == 3) wc = 16'h0000;
                else if (r == 4) wc = 16'($urandom_range(1, 12) * 4 + $urandom_range(1, 3));
                else wc = 16'($urandom_range(1, 12) * 4);
            end
            run_pkt(di, wc, int'($urandom_range(0, 5)), int'($urandom_range(0, 2)), 1'b0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
